// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, data width and baud divider helper.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_e;

    // Clocks per bit, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is always on o_rdata, pop on empty is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot, so a push on a full FIFO is accepted when it coincides with one.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) with mid-bit sampling, sticky error flags and a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit between data and stop).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          rd_en_i,
    input  logic                          clr_err_i,
    output logic [UART_DATA_W-1:0]        data_o,
    output logic                          data_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overrun_o,
    output logic                          frame_err_o
);
    localparam int unsigned       DIV       = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned       BCNT_W    = $clog2(DIV);
    localparam logic [BCNT_W-1:0] HALF_LOAD = BCNT_W'(DIV / 2 - 1);
    localparam logic [BCNT_W-1:0] BIT_LOAD  = BCNT_W'(DIV - 1);

    uart_state_e            r_state;
    uart_state_e            w_state_nxt;
    logic [1:0]             r_sync;
    logic [BCNT_W-1:0]      r_cnt;
    logic [BCNT_W-1:0]      w_cnt_nxt;
    logic [2:0]             r_bit_idx;
    logic [2:0]             w_bit_idx_nxt;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] w_shift_nxt;
    logic                   r_par_err;
    logic                   w_par_err_nxt;
    logic                   r_overrun;
    logic                   r_frame_err;
    logic                   w_rxs;
    logic                   w_push;
    logic                   w_ferr_set;
    logic                   w_ovr_set;
    logic                   w_full;
    logic                   w_empty;

    assign w_rxs = r_sync[1];

    // Synchronizer and FSM datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rxd};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par_err <= w_par_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_par_err_nxt = r_par_err;
        w_push        = 1'b0;
        w_ferr_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt   = ST_START;
                    w_cnt_nxt     = HALF_LOAD;
                    w_par_err_nxt = 1'b0;
                end
            end
            ST_START: begin
                if (r_cnt == '0) begin
                    if (w_rxs) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_DATA;
                        w_cnt_nxt     = BIT_LOAD;
                        w_bit_idx_nxt = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - BCNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_nxt   = {w_rxs, r_shift[UART_DATA_W-1:1]};
                    w_cnt_nxt     = BIT_LOAD;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt - BCNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_cnt == '0) begin
                    w_par_err_nxt = (^r_shift) ^ w_rxs;
                    w_cnt_nxt     = BIT_LOAD;
                    w_state_nxt   = ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt - BCNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (r_cnt == '0) begin
                    if (w_rxs) begin
                        w_push      = !r_par_err;
                        w_ferr_set  = r_par_err;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = ST_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - BCNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A full FIFO only accepts a push when the CPU pops in the same cycle.
    assign w_ovr_set = w_push && w_full && !rd_en_i;

    // Sticky flags; a set event in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (clr_err_i) begin
            r_overrun   <= w_ovr_set;
            r_frame_err <= w_ferr_set;
        end else begin
            r_overrun   <= r_overrun | w_ovr_set;
            r_frame_err <= r_frame_err | w_ferr_set;
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (r_shift),
        .i_pop   (rd_en_i),
        .o_rdata (data_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count_o)
    );

    assign data_valid_o = !w_empty;
    assign overrun_o    = r_overrun;
    assign frame_err_o  = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame-level reference model, per-cycle compare, directed and random frames.
module tb_uart_rx_fifo;
    localparam int unsigned CLK_FREQ = 1000000;
    localparam int unsigned BAUD     = 100000;
    localparam int unsigned DEPTH    = 4;
    localparam int          DIV      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 10 + P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rd_en_i = 1'b0;
    logic       clr_err_i = 1'b0;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic [2:0] count_o;
    logic       overrun_o;
    logic       frame_err_o;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .rd_en_i      (rd_en_i),
        .clr_err_i    (clr_err_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .count_o      (count_o),
        .overrun_o    (overrun_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk = ~clk;

    // Expected outcome of one frame: at cycle at_cyc the stop bit is judged.
    typedef struct {
        int         at_cyc;
        logic       good;
        logic [7:0] data;
    } ev_t;

    ev_t         sched[$];
    logic [7:0]  mq[$];
    logic        m_ovr = 1'b0;
    logic        m_ferr = 1'b0;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int unsigned pop_pct = 0;
    int unsigned clr_pct = 0;
    bit          chk_en = 1'b0;
    logic        e_push, e_fset, e_oset, e_pop;
    logic [7:0]  e_byte;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: queue semantics of the FIFO plus sticky flags, advanced once per clock edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            mq.delete();
            sched.delete();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            e_push = 1'b0;
            e_fset = 1'b0;
            e_oset = 1'b0;
            e_byte = 8'h00;
            if (sched.size() > 0 && sched[0].at_cyc == cyc) begin
                e_push = sched[0].good;
                e_fset = !sched[0].good;
                e_byte = sched[0].data;
                void'(sched.pop_front());
            end
            e_pop = rd_en_i && (mq.size() > 0);
            if (e_push && mq.size() == int'(DEPTH) && !e_pop) e_oset = 1'b1;
            if (e_pop) void'(mq.pop_front());
            if (e_push && !e_oset) mq.push_back(e_byte);
            m_ovr  = clr_err_i ? e_oset : (m_ovr | e_oset);
            m_ferr = clr_err_i ? e_fset : (m_ferr | e_fset);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_valid", int'(data_valid_o), int'(mq.size() != 0));
            chk("count", int'(count_o), mq.size());
            if (mq.size() != 0) chk("data_head", int'(data_o), int'(mq[0]));
            chk("overrun", int'(overrun_o), int'(m_ovr));
            chk("frame_err", int'(frame_err_o), int'(m_ferr));
        end
    end

    // Drive inputs for the next edge, then move to just after that edge.
    task automatic step(input logic rxd_v, input logic pop_v, input logic clr_v, input logic rst_v);
        rxd       = rxd_v;
        rd_en_i   = pop_v | ($urandom_range(99) < pop_pct);
        clr_err_i = clr_v | ($urandom_range(99) < clr_pct);
        rst       = rst_v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Start bit falls right after edge k; the stop bit is judged 3+DIV/2 cycles after the
    // falling edge plus one full bit time per following bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_bad,
                              input int tail_low, input int rst_bit, input logic pop_at_sample);
        logic bits[NB];
        int   k;
        ev_t  ev;
        k = cyc;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
        if (P == 1) bits[9] = (^b) ^ par_bad;
        bits[NB - 1] = stop_v;
        ev.at_cyc = k + 3 + DIV / 2 + (NB - 1) * DIV;
        ev.good   = stop_v && !(P == 1 && par_bad);
        ev.data   = b;
        sched.push_back(ev);
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < DIV; j++) begin
                step(bits[i], pop_at_sample && (cyc + 1 == ev.at_cyc), 1'b0, (i == rst_bit) && (j < 2));
            end
        end
        for (int i = 0; i < tail_low; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] rb;
        logic       bad;
        logic       pbad;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_count", int'(count_o), 0);
        chk("reset_valid", int'(data_valid_o), 0);
        chk("reset_data", int'(data_o), 0);
        chk("reset_overrun", int'(overrun_o), 0);
        chk("reset_frame_err", int'(frame_err_o), 0);
        idle(5);

        // Single good byte, then pop.
        send_frame(8'hA5, 1'b1, 1'b0, 0, -1, 1'b0);
        chk("t1_data", int'(data_o), 'hA5);
        chk("t1_count", int'(count_o), 1);
        chk("t1_valid", int'(data_valid_o), 1);
        pop_one();
        chk("t1_valid_after_pop", int'(data_valid_o), 0);
        idle(5);

        // Short glitch on the line.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(30);
        chk("t2_count", int'(count_o), 0);
        chk("t2_frame_err", int'(frame_err_o), 0);

        // Bad stop bit followed by a held break.
        send_frame(8'h55, 1'b0, 1'b0, 50, -1, 1'b0);
        idle(10);
        chk("t3_frame_err", int'(frame_err_o), 1);
        chk("t3_count", int'(count_o), 0);
        send_frame(8'h3C, 1'b1, 1'b0, 0, -1, 1'b0);
        idle(2);
        chk("t3_data", int'(data_o), 'h3C);
        pop_one();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t3_frame_err_clr", int'(frame_err_o), 0);
        idle(5);

        // Five back-to-back frames into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 0, -1, 1'b0);
        chk("t4_count", int'(count_o), 4);
        chk("t4_overrun", int'(overrun_o), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t4_pop_data", int'(data_o), i);
            pop_one();
        end
        chk("t4_valid_empty", int'(data_valid_o), 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_overrun_clr", int'(overrun_o), 0);
        idle(5);

        // Full FIFO, pop coincides with push.
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b0, 0, -1, 1'b0);
        send_frame(8'h66, 1'b1, 1'b0, 0, -1, 1'b1);
        chk("t5_count", int'(count_o), 4);
        chk("t5_overrun", int'(overrun_o), 0);
        for (int i = 0; i < 4; i++) begin
            chk("t5_pop_data", int'(data_o), (i == 3) ? 'h66 : ('h12 + i));
            pop_one();
        end
        idle(5);

        // Reset in the middle of data bit 4.
        send_frame(8'h77, 1'b1, 1'b0, 0, -1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 0, 5, 1'b0);
        chk("t6_count", int'(count_o), 0);
        chk("t6_valid", int'(data_valid_o), 0);
        chk("t6_data", int'(data_o), 0);
        chk("t6_overrun", int'(overrun_o), 0);
        chk("t6_frame_err", int'(frame_err_o), 0);
        idle(5);
        send_frame(8'h81, 1'b1, (P == 1) ? 1'b1 : 1'b0, 0, -1, 1'b0);
        idle(2);
`ifdef UART_RX_PARITY_EN
        chk("t6_par_frame_err", int'(frame_err_o), 1);
        chk("t6_par_count", int'(count_o), 0);
`else
        chk("t6_data_next", int'(data_o), 'h81);
        chk("t6_count_next", int'(count_o), 1);
`endif
        pop_one();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(5);

        // Random frames with random pops and error clears.
        pop_pct = 30;
        clr_pct = 5;
        for (int n = 0; n < 40; n++) begin
            rb   = 8'($urandom);
            bad  = ($urandom_range(9) == 0);
            pbad = (P == 1) && ($urandom_range(9) == 0);
            send_frame(rb, !bad, pbad, bad ? int'($urandom_range(20)) : 0, -1, 1'b0);
            idle(bad ? int'($urandom_range(12, 3)) : int'($urandom_range(8)));
        end
        pop_pct = 100;
        clr_pct = 0;
        idle(20);
        chk("final_empty", int'(count_o), 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
